l0_skew_fifo_array: RTL

//  - Row-parallel L0 input buffer feeding the systolic MAC array: `row` independent

---
 rtl/l0_skew_fifo_array.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/l0_skew_fifo_array.sv
// l0_skew_fifo_array: row-parallel L0 activation buffer, one FIFO lane per array row, parallel or diagonal-skewed pop.
// Latency: rd sampled at edge t -> o_valid in cycle t+2 (parallel) or t+2+k on lane k (skewed).
// Backpressure: o_ready = ~o_full; full-writes and empty-lane reads are dropped. Optional sticky o_err under L0_ERR_FLAG_EN.
module l0_skew_fifo_array #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic              mode,
    input  logic [row*bw-1:0] in,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty
`ifdef L0_ERR_FLAG_EN
    ,
    output logic              o_err
`endif
);

    localparam int AW = $clog2(depth);

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [bw-1:0]  r_mem [row][depth];
    ptr_t           r_wr_ptr [row];
    ptr_t           r_rd_ptr [row];
    logic [row-1:0] r_rd_en;
    logic           r_mode;

    logic [row-1:0] w_empty;
    logic [row-1:0] w_full;
    logic [row-1:0] w_pop;
    logic [row-1:0] w_rd_en_nxt;
    logic           w_wr_accept;
    logic           w_mode_load;

    // Per-lane flags from pre-edge pointers; a lane pops only if its enable is set and it still holds data.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        w_pop   = '0;
        for (int k = 0; k < row; k++) begin
            w_empty[k] = (r_wr_ptr[k] == r_rd_ptr[k]);
            w_full[k]  = (r_wr_ptr[k][AW] != r_rd_ptr[k][AW]) &&
                         (r_wr_ptr[k][AW-1:0] == r_rd_ptr[k][AW-1:0]);
            w_pop[k]   = r_rd_en[k] & ~w_empty[k];
        end
    end

    assign o_full      = |w_full;
    assign o_ready     = ~o_full;
    assign o_empty     = &w_empty;
    assign w_wr_accept = wr & o_ready;
    // Mode may only change when no request is pending and none is in flight.
    assign w_mode_load = ~rd & ~(|r_rd_en);

    // Next read enables: parallel arms every non-empty lane; skewed shifts the wavefront one lane per cycle,
    // dying at the first lane found empty.
    always_comb begin
        w_rd_en_nxt    = '0;
        w_rd_en_nxt[0] = rd & ~w_empty[0];
        for (int k = 1; k < row; k++) begin
            if (r_mode) begin
                w_rd_en_nxt[k] = r_rd_en[k-1] & ~w_empty[k];
            end else begin
                w_rd_en_nxt[k] = rd & ~w_empty[k];
            end
        end
    end

    // Read-enable pipeline and run-time mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_rd_en <= w_rd_en_nxt;
            if (w_mode_load) begin
                r_mode <= mode;
            end
        end
    end

    // Lane storage: all lanes take their slice of the input word together.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            for (int k = 0; k < row; k++) begin
                r_mem[k][r_wr_ptr[k][AW-1:0]] <= in[k*bw +: bw];
            end
        end
    end

    // Pointer update: writes gated by global full, reads by each lane's pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < row; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < row; k++) begin
                if (w_wr_accept) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + PTR_ONE;
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_ONE;
                end
            end
        end
    end

    // Registered output: popped head per lane; idle lanes hold their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            o_valid <= '0;
        end else begin
            o_valid <= w_pop;
            for (int k = 0; k < row; k++) begin
                if (w_pop[k]) begin
                    out[k*bw +: bw] <= r_mem[k][r_rd_ptr[k][AW-1:0]];
                end
            end
        end
    end

`ifdef L0_ERR_FLAG_EN
    logic r_err;

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((wr & o_full) | (rd & o_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule
